// File: rtl/ex_pkg.sv
// Shared definitions for the EX stage and its iterative multiply/divide engine.
// Holds the alu_op encodings, funct codes, engine state type and op selector.
package ex_pkg;

  // alu_op_in encodings
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

  // funct_in codes decoded when alu_op_in selects the funct field
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_MUL  = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_DIVU = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } md_state_t;

  typedef enum logic [1:0] {
    MD_MUL,
    MD_DIV,
    MD_DIVU
  } md_op_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_fn_t;

  function automatic logic is_muldiv(input logic [1:0] alu_op, input logic [5:0] funct);
    return (alu_op == ALUOP_FUNCT) &&
           ((funct == FN_MUL) || (funct == FN_DIV) || (funct == FN_DIVU));
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative 32-step multiply / restoring divide engine.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   flush_i         - abort any operation and return to idle
//   start_i         - launch op_i on a_i/b_i (only honoured while idle)
//   op_i            - MD_MUL, MD_DIV (signed) or MD_DIVU
//   a_i, b_i        - operands (multiplicand/dividend, multiplier/divisor)
//   idle_o, run_o, done_o - current engine state
//   result_o        - low product word or quotient, valid while done_o
module muldiv_iter
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        start_i,
  input  md_op_t      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        idle_o,
  output logic        run_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  md_state_t   state_q;
  logic [4:0]  cnt_q;
  md_op_t      op_q;
  logic        neg_q;    // signed DIV: operand signs differ
  logic        dz_q;     // divisor was zero
  logic [31:0] acc_q;    // MUL partial product
  logic [31:0] x_q;      // MUL multiplicand (shifts left) / DIV divisor magnitude
  logic [31:0] y_q;      // MUL multiplier (shifts right) / DIV dividend->quotient
  logic [31:0] rem_q;    // DIV partial remainder

  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_sh, rem_diff;
  logic [31:0] acc_d, x_d, y_d, rem_d;

  always_comb begin
    a_mag = ((op_i == MD_DIV) && a_i[31]) ? (~a_i + 32'd1) : a_i;
    b_mag = ((op_i == MD_DIV) && b_i[31]) ? (~b_i + 32'd1) : b_i;

    acc_d = acc_q;
    x_d   = x_q;
    y_d   = y_q;
    rem_d = rem_q;

    // Restoring step: the borrow out of rem_diff tells whether the divisor fits.
    rem_sh   = {rem_q, y_q[31]};
    rem_diff = rem_sh - {1'b0, x_q};

    if (op_q == MD_MUL) begin
      if (y_q[0]) acc_d = acc_q + x_q;
      x_d = {x_q[30:0], 1'b0};
      y_d = {1'b0, y_q[31:1]};
    end else begin
      if (!rem_diff[32]) begin
        rem_d = rem_diff[31:0];
        y_d   = {y_q[30:0], 1'b1};
      end else begin
        rem_d = rem_sh[31:0];
        y_d   = {y_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MUL;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rem_q   <= '0;
    end else if (flush_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            op_q    <= op_i;
            neg_q   <= (op_i == MD_DIV) && (a_i[31] ^ b_i[31]);
            dz_q    <= (b_i == '0);
            acc_q   <= '0;
            rem_q   <= '0;
            if (op_i == MD_MUL) begin
              x_q <= a_i;
              y_q <= b_i;
            end else begin
              x_q <= b_mag;
              y_q <= a_mag;
            end
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          x_q   <= x_d;
          y_q   <= y_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign idle_o = (state_q == ST_IDLE);
  assign run_o  = (state_q == ST_RUN);
  assign done_o = (state_q == ST_DONE);

  // Magnitude division then sign fix truncates toward zero; 0x80000000/-1
  // falls out naturally as 0x80000000.
  always_comb begin
    if (op_q == MD_MUL)  result_o = acc_q;
    else if (dz_q)       result_o = '1;
    else if (neg_q)      result_o = ~y_q + 32'd1;
    else                 result_o = y_q;
  end

endmodule

// File: rtl/ex_muldiv_stage.sv
// EX pipeline stage: single-cycle ALU plus iterative MUL/DIV/DIVU, feeding
// the EX/MEM register.
// Ports:
//   clk, reset, flush_in            - clock, sync active-high reset, EX squash
//   *_in control / data             - ID/EX register contents
//   reg_write_out .. mem_write_out  - registered EX/MEM control
//   alu_result_out, store_data_out, rd_out, zero_out - registered EX/MEM data
//   stall_out                       - combinational; holds ID/EX and upstream
module ex_muldiv_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        alu_src_in,
  input  logic        reg_dst_in,
  input  logic [1:0]  alu_op_in,
  input  logic [31:0] rs1_data_in,
  input  logic [31:0] rs2_data_in,
  input  logic [31:0] imm_in,
  input  logic [4:0]  rs2_in,
  input  logic [4:0]  rd_in,
  input  logic [5:0]  funct_in,
  input  logic [5:0]  opcode_in,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_data_out,
  output logic [4:0]  rd_out,
  output logic        zero_out,
  output logic        stall_out
);

  logic        unused_opcode;
  assign unused_opcode = ^opcode_in;

  logic [31:0] op_b, alu_res, ex_result;
  alu_fn_t     alu_fn;
  logic        md_req, md_start;
  md_op_t      md_op;
  logic        md_idle, md_run, md_done;
  logic [31:0] md_result;

  always_comb begin
    op_b   = alu_src_in ? imm_in : rs2_data_in;
    alu_fn = ALU_ADD;
    case (alu_op_in)
      ALUOP_SUB: alu_fn = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_in)
          FN_SUB:  alu_fn = ALU_SUB;
          FN_AND:  alu_fn = ALU_AND;
          FN_OR:   alu_fn = ALU_OR;
          FN_SLT:  alu_fn = ALU_SLT;
          default: alu_fn = ALU_ADD;
        endcase
      end
      default: alu_fn = ALU_ADD;
    endcase

    case (alu_fn)
      ALU_SUB: alu_res = rs1_data_in - op_b;
      ALU_AND: alu_res = rs1_data_in & op_b;
      ALU_OR:  alu_res = rs1_data_in | op_b;
      ALU_SLT: alu_res = {31'b0, $signed(rs1_data_in) < $signed(op_b)};
      default: alu_res = rs1_data_in + op_b;
    endcase

    md_req = is_muldiv(alu_op_in, funct_in);
    if (funct_in == FN_MUL)      md_op = MD_MUL;
    else if (funct_in == FN_DIV) md_op = MD_DIV;
    else                         md_op = MD_DIVU;
  end

  // The instruction stays parked in ID/EX through RUN, so in DONE the inputs
  // still describe it; releasing the stall there advances the pipe past it.
  assign md_start  = md_req && md_idle && !flush_in;
  assign stall_out = !reset && !flush_in && ((md_idle && md_req) || md_run);

  muldiv_iter u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush_in),
    .start_i  (md_start),
    .op_i     (md_op),
    .a_i      (rs1_data_in),
    .b_i      (op_b),
    .idle_o   (md_idle),
    .run_o    (md_run),
    .done_o   (md_done),
    .result_o (md_result)
  );

  assign ex_result = md_done ? md_result : alu_res;

  logic        reg_write_q, mem_to_reg_q, mem_read_q, mem_write_q, zero_q;
  logic [31:0] alu_result_q, store_data_q;
  logic [4:0]  rd_q;

  always_ff @(posedge clk) begin
    if (reset || flush_in || stall_out) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_result_q <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      zero_q       <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_in;
      mem_to_reg_q <= mem_to_reg_in;
      mem_read_q   <= mem_read_in;
      mem_write_q  <= mem_write_in;
      alu_result_q <= ex_result;
      store_data_q <= rs2_data_in;
      rd_q         <= reg_dst_in ? rd_in : rs2_in;
      zero_q       <= (ex_result == '0);
    end
  end

  assign reg_write_out  = reg_write_q;
  assign mem_to_reg_out = mem_to_reg_q;
  assign mem_read_out   = mem_read_q;
  assign mem_write_out  = mem_write_q;
  assign alu_result_out = alu_result_q;
  assign store_data_out = store_data_q;
  assign rd_out         = rd_q;
  assign zero_out       = zero_q;

endmodule
